// File: rtl/glitch_sweep_ctrl_if.sv
// rtl/glitch_sweep_ctrl_if.sv - pulser-side bundle between the sweep controller and the pulser
interface glitch_sweep_ctrl_if #(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8
) ();
    logic               pulser_en_o;
    logic [DELAY_W-1:0] delay_o;
    logic [WIDTH_W-1:0] width_o;
    logic               pulser_ready_i;

    modport master (
        output pulser_en_o,
        output delay_o,
        output width_o,
        input  pulser_ready_i
    );

    modport slave (
        input  pulser_en_o,
        input  delay_o,
        input  width_o,
        output pulser_ready_i
    );
endinterface

// File: rtl/glitch_sweep_ctrl.sv
// rtl/glitch_sweep_ctrl.sv - delay x pulse-width sweep sequencer for the pulser (optional GLITCH_SWEEP_TIMEOUT_EN)
module glitch_sweep_ctrl #(
    parameter int DELAY_W        = 16,
    parameter int WIDTH_W        = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               trigger_i,
    input  logic [DELAY_W-1:0] delay_start_i,
    input  logic [DELAY_W-1:0] delay_end_i,
    input  logic [DELAY_W-1:0] delay_step_i,
    input  logic [WIDTH_W-1:0] width_start_i,
    input  logic [WIDTH_W-1:0] width_end_i,
    input  logic [WIDTH_W-1:0] width_step_i,
    glitch_sweep_ctrl_if.master pulser,
    output logic               busy_o,
    output logic               done_o,
    output logic [15:0]        attempt_cnt_o,
    output logic               timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FIRE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_STEP
    } state_t;

    localparam logic [DELAY_W-1:0] DELAY_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_W-1:0] WIDTH_ONE = {{(WIDTH_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               trig_prev_q;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [WIDTH_W-1:0] width_q, width_d;
    logic [DELAY_W-1:0] d_start_q, d_start_d, d_end_q, d_end_d, d_step_q, d_step_d;
    logic [WIDTH_W-1:0] w_start_q, w_start_d, w_end_q, w_end_d, w_step_q, w_step_d;
    logic [15:0]        attempt_q, attempt_d;
    logic               done_q, done_d;

    // One extra bit on the sums so the end comparison cannot be fooled by wrap-around.
    logic [WIDTH_W:0]   next_width;
    logic [DELAY_W:0]   next_delay;
    logic               edge_ok;

`ifdef GLITCH_SWEEP_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0]        to_cnt_q, to_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    assign edge_ok    = trigger_i & ~trig_prev_q & pulser.pulser_ready_i;
    assign next_width = {1'b0, width_q} + {1'b0, w_step_q};
    assign next_delay = {1'b0, delay_q} + {1'b0, d_step_q};

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        width_d   = width_q;
        d_start_d = d_start_q;
        d_end_d   = d_end_q;
        d_step_d  = d_step_q;
        w_start_d = w_start_q;
        w_end_d   = w_end_q;
        w_step_d  = w_step_q;
        attempt_d = attempt_q;
        done_d    = 1'b0;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        timeout_d = timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_i && pulser.pulser_ready_i) begin
                    d_start_d = delay_start_i;
                    d_end_d   = delay_end_i;
                    d_step_d  = (delay_step_i == '0) ? DELAY_ONE : delay_step_i;
                    w_start_d = width_start_i;
                    w_end_d   = width_end_i;
                    w_step_d  = (width_step_i == '0) ? WIDTH_ONE : width_step_i;
                    delay_d   = delay_start_i;
                    width_d   = width_start_i;
                    attempt_d = '0;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
`ifdef GLITCH_SWEEP_TIMEOUT_EN
                // Timeout outranks a trigger edge landing on the final ARM cycle.
                if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                    if (edge_ok) begin
                        state_d = S_FIRE;
                    end
                end
`else
                if (edge_ok) begin
                    state_d = S_FIRE;
                end
`endif
            end
            S_FIRE: begin
                if (attempt_q != 16'hFFFF) begin
                    attempt_d = attempt_q + 16'd1;
                end
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (!pulser.pulser_ready_i) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (pulser.pulser_ready_i) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (next_width <= {1'b0, w_end_q}) begin
                    width_d = next_width[WIDTH_W-1:0];
                    state_d = S_ARM;
                end else if (next_delay <= {1'b0, d_end_q}) begin
                    width_d = w_start_q;
                    delay_d = next_delay[DELAY_W-1:0];
                    state_d = S_ARM;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything; sweep position and counters are left intact.
        if (state_q != S_IDLE && abort_i) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            delay_d = delay_q;
            width_d = width_q;
`ifdef GLITCH_SWEEP_TIMEOUT_EN
            timeout_d = timeout_q;
`endif
        end

`ifdef GLITCH_SWEEP_TIMEOUT_EN
        if (state_d == S_ARM && state_q != S_ARM) begin
            to_cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            trig_prev_q <= 1'b0;
            delay_q     <= '0;
            width_q     <= '0;
            d_start_q   <= '0;
            d_end_q     <= '0;
            d_step_q    <= '0;
            w_start_q   <= '0;
            w_end_q     <= '0;
            w_step_q    <= '0;
            attempt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_prev_q <= trigger_i;
            delay_q     <= delay_d;
            width_q     <= width_d;
            d_start_q   <= d_start_d;
            d_end_q     <= d_end_d;
            d_step_q    <= d_step_d;
            w_start_q   <= w_start_d;
            w_end_q     <= w_end_d;
            w_step_q    <= w_step_d;
            attempt_q   <= attempt_d;
            done_q      <= done_d;
        end
    end

`ifdef GLITCH_SWEEP_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    // Enable is decoded from the state register so reset clears it without a clock.
    assign pulser.pulser_en_o = (state_q == S_FIRE);
    assign pulser.delay_o     = delay_q;
    assign pulser.width_o     = width_q;
    assign busy_o             = (state_q != S_IDLE);
    assign done_o             = done_q;
    assign attempt_cnt_o      = attempt_q;

endmodule
